// File: rtl/auto_player.sv
// auto_player: drives an emulated push-button into the reaction game. Each
// time the LED display lights up, it waits a programmable number of slowen
// ticks, then holds the button for HOLD_TICKS ticks. It presses only once per
// lit period.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   slowen       one-clk tick enable; all delays count these ticks
//   enable       1 = player active, 0 = parked in IDLE
//   leds_in      game LED bus (same clock domain)
//   reaction     reaction delay in ticks, latched at the start of each round
//   pb_out       registered push-button level, high exactly while in PRESS
//   busy         registered, high in REACT or PRESS
//   press_count  saturating count of presses issued
//   state        current FSM state code, for debug
//
// Handshake: this block has no valid/ready channels. Inputs are plain
// levels, and outputs are registered levels that change only on clk or rst.
module auto_player #(
  parameter int REACT_W    = 8,
  parameter int HOLD_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slowen,
  input  logic               enable,
  input  logic [6:0]         leds_in,
  input  logic [REACT_W-1:0] reaction,
  output logic               pb_out,
  output logic               busy,
  output logic [7:0]         press_count,
  output logic [2:0]         state
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  // The hold phase ends on the edge that carries the last tick, so the
  // counter only needs to reach HOLD_TICKS-1 before that edge.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_WAIT_ON = 3'd2,
    S_REACT   = 3'd3,
    S_PRESS   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [REACT_W-1:0] react_cnt_q, react_cnt_d;
  logic [REACT_W-1:0] react_lat_q, react_lat_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [7:0]         press_cnt_q, press_cnt_d;
  logic               pb_q, pb_d;
  logic               busy_q, busy_d;

  logic leds_dark;
  assign leds_dark = (leds_in == 7'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      react_cnt_q <= '0;
      react_lat_q <= '0;
      hold_cnt_q  <= '0;
      press_cnt_q <= '0;
      pb_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      react_cnt_q <= react_cnt_d;
      react_lat_q <= react_lat_d;
      hold_cnt_q  <= hold_cnt_d;
      press_cnt_q <= press_cnt_d;
      pb_q        <= pb_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    react_cnt_d = react_cnt_q;
    react_lat_d = react_lat_q;
    hold_cnt_d  = hold_cnt_q;
    press_cnt_d = press_cnt_q;
    pb_d        = 1'b0;
    busy_d      = 1'b0;

    // Dropping enable parks the player from any state, ahead of every other rule.
    if ((state_q != S_IDLE) && !enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (enable) state_d = S_ARM;
        // Wait for a dark display first, so we never press into a display
        // that was already lit when the player woke up.
        S_ARM:     if (leds_dark) state_d = S_WAIT_ON;
        S_WAIT_ON: begin
          if (!leds_dark) begin
            state_d     = S_REACT;
            react_lat_d = reaction;
            react_cnt_d = '0;
          end
        end
        S_REACT: begin
          if (leds_dark) begin
            state_d = S_WAIT_ON;          // round aborted, no press
          end else if (react_cnt_q == react_lat_q) begin
            state_d = S_PRESS;
          end else if (slowen) begin
            react_cnt_d = react_cnt_q + 1'b1;
          end
        end
        S_PRESS: begin
          if (slowen) begin
            if (hold_cnt_q == HOLD_LAST) state_d = S_DONE;
            else                         hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        S_DONE:    if (leds_dark) state_d = S_WAIT_ON;
        default:   state_d = S_IDLE;      // unused codes 6 and 7
      endcase
    end

    if ((state_d == S_PRESS) && (state_q != S_PRESS)) begin
      hold_cnt_d = '0;
      if (press_cnt_q != 8'hFF) press_cnt_d = press_cnt_q + 8'd1;
    end

    // Decode the next state so that pb_out and busy are registered and
    // line up with state on every edge.
    pb_d   = (state_d == S_PRESS);
    busy_d = (state_d == S_REACT) || (state_d == S_PRESS);
  end

  assign pb_out      = pb_q;
  assign busy        = busy_q;
  assign press_count = press_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_auto_player.sv
module tb_auto_player;

  localparam int REACT_W    = 8;
  localparam int HOLD_TICKS = 4;

  // State codes as the design publishes them on its debug port.
  localparam int ST_IDLE  = 0;
  localparam int ST_ARM   = 1;
  localparam int ST_WAIT  = 2;
  localparam int ST_REACT = 3;
  localparam int ST_PRESS = 4;
  localparam int ST_DONE  = 5;

  // ---------------- clock / reset ----------------
  logic               clk      = 1'b0;
  logic               rst      = 1'b1;
  logic               slowen   = 1'b0;
  logic               enable   = 1'b0;
  logic [6:0]         leds_in  = 7'd0;
  logic [REACT_W-1:0] reaction = '0;
  logic               pb_out;
  logic               busy;
  logic [7:0]         press_count;
  logic [2:0]         state;

  always #5 clk = ~clk;

  auto_player #(.REACT_W(REACT_W), .HOLD_TICKS(HOLD_TICKS)) dut (
    .clk         (clk),
    .rst         (rst),
    .slowen      (slowen),
    .enable      (enable),
    .leds_in     (leds_in),
    .reaction    (reaction),
    .pb_out      (pb_out),
    .busy        (busy),
    .press_count (press_count),
    .state       (state)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int sl_mode = 0;  // 0 random ticks, 1 one tick per 4 clks, 2 tick every clk

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Round-level view of the player: which phase of the round it is in,
  // how many reaction ticks it has waited, and how many hold ticks it has
  // given. The published state code is just the phase number.
  int m_phase, m_delay, m_waited, m_held, m_presses;

  function automatic void model_reset();
    m_phase = ST_IDLE; m_delay = 0; m_waited = 0; m_held = 0; m_presses = 0;
  endfunction

  function automatic void model_step();
    int nxt;
    bit lit;
    lit = (leds_in != 0);
    nxt = m_phase;
    if (m_phase != ST_IDLE && !enable) nxt = ST_IDLE;
    else if (m_phase == ST_IDLE) begin
      if (enable) nxt = ST_ARM;
    end else if (m_phase == ST_ARM) begin
      if (!lit) nxt = ST_WAIT;
    end else if (m_phase == ST_WAIT) begin
      if (lit) begin nxt = ST_REACT; m_delay = int'(reaction); m_waited = 0; end
    end else if (m_phase == ST_REACT) begin
      if (!lit) nxt = ST_WAIT;
      else if (m_waited >= m_delay) nxt = ST_PRESS;
      else if (slowen) m_waited++;
    end else if (m_phase == ST_PRESS) begin
      if (slowen) begin
        m_held++;
        if (m_held >= HOLD_TICKS) nxt = ST_DONE;
      end
    end else if (m_phase == ST_DONE) begin
      if (!lit) nxt = ST_WAIT;
    end else nxt = ST_IDLE;
    if (nxt == ST_PRESS && m_phase != ST_PRESS) begin
      m_held = 0;
      m_presses = (m_presses >= 255) ? 255 : m_presses + 1;
    end
    m_phase = nxt;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    case (sl_mode)
      0:       slowen = ($urandom_range(0, 3) == 0);
      1:       slowen = ((cyc % 4) == 3);
      default: slowen = 1'b1;
    endcase
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("state", 32'(state), 32'(m_phase));
    check("pb_out", 32'(pb_out), 32'(m_phase == ST_PRESS));
    check("busy", 32'(busy), 32'(m_phase == ST_REACT || m_phase == ST_PRESS));
    check("press_count", 32'(press_count), 32'(m_presses));
  endtask

  task automatic wait_state(input int target, input int bound, input string tag);
    int n = 0;
    while (int'(state) != target && n < bound) begin step(); n++; end
    check(tag, 32'(state), 32'(target));
  endtask

  task automatic wait_pb(input int bound, input string tag);
    int n = 0;
    while (!pb_out && n < bound) begin step(); n++; end
    check(tag, 32'(pb_out), 32'd1);
  endtask

  // Called just after a rising edge; raises rst between edges and checks
  // that the outputs clear without any clock.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check({tag, "_pb"}, 32'(pb_out), 32'd0);
    check({tag, "_state"}, 32'(state), ST_IDLE);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(press_count), 32'd0);
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ticks, n;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), ST_IDLE);
    check("rst_pb", 32'(pb_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(press_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic press: reaction 3, one tick every 4 clocks.
    sl_mode = 1; enable = 1'b1; leds_in = 7'd0; reaction = 8'd3;
    repeat (4) step();
    leds_in = 7'h7F;
    step();                               // WAIT_ON -> REACT
    ticks = 0; n = 0;
    while (!pb_out && n < 60) begin
      step(); n++;
      if (!pb_out && slowen) ticks++;
    end
    check("basic_pb_rise", 32'(pb_out), 32'd1);
    check("basic_react_ticks", 32'(ticks), 32'd3);
    ticks = 0; n = 0;
    while (pb_out && n < 60) begin
      step(); n++;
      if (slowen) ticks++;
    end
    check("basic_hold_ticks", 32'(ticks), HOLD_TICKS);
    check("basic_done", 32'(state), ST_DONE);
    check("basic_count", 32'(press_count), 32'd1);
    leds_in = 7'd0;
    step();

    // Zero reaction: press two clocks after the display lights.
    reaction = 8'd0; leds_in = 7'h01; n = 0;
    do begin step(); n++; end while (!pb_out && n < 10);
    check("zero_react_latency", 32'(n), 32'd2);
    wait_state(ST_DONE, 60, "zero_done");
    leds_in = 7'd0;
    step();

    // Abort after one of five ticks.
    reaction = 8'd5; leds_in = 7'h10;
    step();
    ticks = 0; n = 0;
    while (ticks < 1 && n < 20) begin step(); n++; if (slowen) ticks++; end
    leds_in = 7'd0;
    repeat (3) step();
    check("abort_state", 32'(state), ST_WAIT);
    check("abort_count", 32'(press_count), 32'd2);

    // Display already lit when the player is enabled.
    async_reset("rst_idle");
    leds_in = 7'h08; reaction = 8'd0;
    repeat (6) step();
    check("lit_stays_arm", 32'(state), ST_ARM);
    check("lit_no_press", 32'(press_count), 32'd0);
    leds_in = 7'd0;
    step();
    leds_in = 7'h08;
    wait_pb(10, "lit_then_press");

    // Disable while pressing.
    enable = 1'b0;
    step();
    check("dis_pb", 32'(pb_out), 32'd0);
    check("dis_state", 32'(state), ST_IDLE);
    enable = 1'b1;
    repeat (3) step();
    leds_in = 7'd0;
    repeat (2) step();
    leds_in = 7'h22;
    wait_pb(10, "press_before_rst");
    async_reset("rst_press");

    // Randomized operation, with reaction changing mid-round.
    sl_mode = 0; enable = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0)
        leds_in = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      enable   = ($urandom_range(0, 63) != 0);
      reaction = 8'($urandom_range(0, 6));
      step();
    end

    // Saturation over 260 complete rounds.
    async_reset("rst_sat");
    sl_mode = 2; enable = 1'b1; leds_in = 7'd0; reaction = 8'd0;
    repeat (3) step();
    repeat (260) begin
      leds_in = 7'($urandom_range(1, 127));
      wait_state(ST_DONE, 20, "sat_round_done");
      leds_in = 7'd0;
      step();
    end
    check("sat_count", 32'(press_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
